// File: rtl/pkg_ram.sv
`default_nettype none
// ============================================================================
//  Module      : pkg_ram
//  Description : Shared RAM-side types used by the loader/console path.
//  Revision    : 1.0 - initial release
// ============================================================================
package pkg_ram;

  // One byte as seen by the loader and its RAM.
  typedef logic [7:0] RAM_BYTE;

endpackage
`default_nettype wire

// File: rtl/pkg_uart.sv
`default_nettype none
// ============================================================================
//  Module      : pkg_uart
//  Description : Types and constants shared by the UART receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package pkg_uart;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_t;

  // 12 MHz system clock, 115200 baud.
  localparam int UART_CLKS_PER_BIT = 104;
  localparam int UART_DATA_BITS    = 8;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Generic two-flop synchronizer for a single asynchronous bit.
//                Both flops reset to RESET_VAL.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture; the first stage may go metastable, the second settles it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 LSB-first serial receiver. Produces a one-cycle data_en
//                strobe per good byte and a one-cycle frame_err strobe when
//                the stop bit is sampled low. No buffering.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import pkg_uart::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  output pkg_ram::RAM_BYTE data,
  output logic            data_en,
  output logic            frame_err,
  output logic            busy
);

  // Full bit period and half bit period terminal counts (integer division).
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       C_BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic                      w_rx_s;
  uart_state_t               r_state,    w_state_nxt;
  logic [CNT_W-1:0]          r_cnt,      w_cnt_nxt;
  logic [2:0]                r_bit_idx,  w_bit_idx_nxt;
  logic [UART_DATA_BITS-1:0] r_shift,    w_shift_nxt;
  pkg_ram::RAM_BYTE          r_data,     w_data_nxt;
  logic                      r_data_en,  w_data_en_nxt;
  logic                      r_frame_err, w_frame_err_nxt;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (w_rx_s)
  );

  // State, counters, shift register and output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_data_en   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_data_en   <= w_data_en_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Next-state logic; STOP leaves at mid-bit so a back-to-back start is caught.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_data_nxt      = r_data;
    w_data_en_nxt   = 1'b0;
    w_frame_err_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
        end
      end
      START: begin
        if (r_cnt == C_CNT_HALF) begin
          w_cnt_nxt = '0;
          if (!w_rx_s) begin
            w_state_nxt   = DATA;
            w_bit_idx_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (r_cnt == C_CNT_FULL) begin
          w_cnt_nxt              = '0;
          w_shift_nxt[r_bit_idx] = w_rx_s;
          if (r_bit_idx == C_BIT_LAST) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (r_cnt == C_CNT_FULL) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_data_nxt    = r_shift;
            w_data_en_nxt = 1'b1;
            w_state_nxt   = IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        // Hold off until the line returns high so a break cannot fake a start.
        if (w_rx_s) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign data      = r_data;
  assign data_en   = r_data_en;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx (16 and 13 clk/bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx16 = 1'b1;
  logic       rx13 = 1'b1;
  logic [7:0] data16, data13;
  logic       data_en16, data_en13;
  logic       frame_err16, frame_err13;
  logic       busy16, busy13;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Monitor bookkeeping
  int         n_en16 = 0, n_fe16 = 0, n_en13 = 0, n_fe13 = 0, n_ovl = 0;
  int         t_en16 [$];
  int         t_en13 [$];
  logic [7:0] q16 [$];
  logic [7:0] q13 [$];
  logic       busy_seen16 = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .rx(rx16), .data(data16),
    .data_en(data_en16), .frame_err(frame_err16), .busy(busy16)
  );

  uart_rx #(.CLKS_PER_BIT(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .rx(rx13), .data(data13),
    .data_en(data_en13), .frame_err(frame_err13), .busy(busy13)
  );

  // Record strobes away from the active edge.
  always @(negedge clk) begin
    if (data_en16) begin
      n_en16++;
      t_en16.push_back(cyc);
      q16.push_back(data16);
    end
    if (frame_err16) n_fe16++;
    if (data_en13) begin
      n_en13++;
      t_en13.push_back(cyc);
      q13.push_back(data13);
    end
    if (frame_err13) n_fe13++;
    if ((data_en16 && frame_err16) || (data_en13 && frame_err13)) n_ovl++;
    if (busy16) busy_seen16 = 1'b1;
  end

  task automatic clear_mon();
    n_en16 = 0; n_fe16 = 0; n_en13 = 0; n_fe13 = 0;
    t_en16.delete(); t_en13.delete(); q16.delete(); q13.delete();
    busy_seen16 = 1'b0;
  endtask

  // Hold one line level for n clocks; entered and left at 1 time unit past an edge.
  task automatic drive(input int which, input logic v, input int n);
    if (which == 0) rx16 = v; else rx13 = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int which, input logic [7:0] b, input logic stopv, input int extra_stop);
    int cpb;
    cpb = (which == 0) ? 16 : 13;
    drive(which, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(which, b[i], cpb);
    drive(which, stopv, cpb + extra_stop);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (data16 !== 8'h00 || data_en16 !== 1'b0 || frame_err16 !== 1'b0 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h en=%b ferr=%b busy=%b, want 00 0 0 0",
               data16, data_en16, frame_err16, busy16);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 1'b1, 10);
    checks++;
    if (busy16 !== 1'b0 || n_en16 != 0) begin
      errors++;
      $display("FAIL reset_release: busy=%b en_count=%0d, want 0 0", busy16, n_en16);
    end
  endtask

  task automatic test_single_byte();
    int t_fall;
    clear_mon();
    t_fall = cyc;
    send(0, 8'h34, 1'b1, 0);
    drive(0, 1'b1, 16);
    checks++;
    if (n_en16 != 1 || q16.size() != 1) begin
      errors++;
      $display("FAIL single_count: data_en pulses=%0d, want 1", n_en16);
    end else begin
      checks++;
      if (q16[0] !== 8'h34) begin
        errors++;
        $display("FAIL single_data: got %h, want 34", q16[0]);
      end
      checks++;
      if (t_en16[0] - t_fall != 155) begin
        errors++;
        $display("FAIL single_latency: got %0d clk, want 155", t_en16[0] - t_fall);
      end
    end
    checks++;
    if (n_fe16 != 0 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: frame_err pulses=%0d busy=%b, want 0 0", n_fe16, busy16);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send(0, 8'h3E, 1'b1, 0);
    send(0, 8'h61, 1'b1, 0);
    drive(0, 1'b1, 16);
    checks++;
    if (n_en16 != 2) begin
      errors++;
      $display("FAIL b2b_count: data_en pulses=%0d, want 2", n_en16);
    end else begin
      checks++;
      if (q16[0] !== 8'h3E || q16[1] !== 8'h61) begin
        errors++;
        $display("FAIL b2b_data: got %h %h, want 3e 61", q16[0], q16[1]);
      end
      checks++;
      if (t_en16[1] - t_en16[0] != 160) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d clk, want 160", t_en16[1] - t_en16[0]);
      end
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    drive(0, 1'b0, 5);
    drive(0, 1'b1, 30);
    checks++;
    if (n_en16 != 0 || n_fe16 != 0) begin
      errors++;
      $display("FAIL glitch_strobes: en=%0d ferr=%0d, want 0 0", n_en16, n_fe16);
    end
    checks++;
    if (busy_seen16 !== 1'b1 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy: seen=%b now=%b, want 1 0", busy_seen16, busy16);
    end
    checks++;
    if (data16 !== 8'h61) begin
      errors++;
      $display("FAIL glitch_data: got %h, want 61", data16);
    end
  endtask

  task automatic test_frame_error();
    clear_mon();
    send(0, 8'hC3, 1'b0, 40);
    drive(0, 1'b1, 20);
    checks++;
    if (n_fe16 != 1 || n_en16 != 0) begin
      errors++;
      $display("FAIL ferr_strobes: ferr=%0d en=%0d, want 1 0", n_fe16, n_en16);
    end
    checks++;
    if (data16 !== 8'h61 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL ferr_hold: data=%h busy=%b, want 61 0", data16, busy16);
    end
    send(0, 8'h55, 1'b1, 0);
    drive(0, 1'b1, 16);
    checks++;
    if (n_en16 != 1 || data16 !== 8'h55) begin
      errors++;
      $display("FAIL ferr_recover: en=%0d data=%h, want 1 55", n_en16, data16);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] b;
    clear_mon();
    b = 8'h5A;
    drive(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive(0, b[i], 16);
    drive(0, b[4], 5);
    checks++;
    if (busy16 !== 1'b1 || data16 !== 8'h55) begin
      errors++;
      $display("FAIL rst_pre: busy=%b data=%h, want 1 55", busy16, data16);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (data16 !== 8'h00 || data_en16 !== 1'b0 || frame_err16 !== 1'b0 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: data=%h en=%b ferr=%b busy=%b, want 00 0 0 0",
               data16, data_en16, frame_err16, busy16);
    end
    rx16 = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 1'b1, 8);
    send(0, 8'hA5, 1'b1, 0);
    drive(0, 1'b1, 16);
    checks++;
    if (n_en16 != 1 || data16 !== 8'hA5) begin
      errors++;
      $display("FAIL rst_recover: en=%0d data=%h, want 1 a5", n_en16, data16);
    end
  endtask

  task automatic test_odd_divisor();
    clear_mon();
    send(1, 8'hFF, 1'b1, 0);
    send(1, 8'h00, 1'b1, 0);
    drive(1, 1'b1, 20);
    checks++;
    if (n_en13 != 2 || n_fe13 != 0) begin
      errors++;
      $display("FAIL odd_count: en=%0d ferr=%0d, want 2 0", n_en13, n_fe13);
    end else begin
      checks++;
      if (q13[0] !== 8'hFF || q13[1] !== 8'h00) begin
        errors++;
        $display("FAIL odd_data: got %h %h, want ff 00", q13[0], q13[1]);
      end
      checks++;
      if (t_en13[1] - t_en13[0] != 130) begin
        errors++;
        $display("FAIL odd_spacing: got %0d clk, want 130", t_en13[1] - t_en13[0]);
      end
    end
  endtask

  task automatic test_no_overlap();
    checks++;
    if (n_ovl != 0) begin
      errors++;
      $display("FAIL strobe_overlap: %0d cycles with data_en and frame_err both high, want 0", n_ovl);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_async_reset();
    test_odd_divisor();
    test_no_overlap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial byte receiver that feeds the hex loader/console path: turns the FPGA RX pin into one-cycle byte strobes.
- 8N1 framing, LSB first, fixed baud set by a clock-divider parameter.
- Output pair (data, data_en) is the byte stream consumed directly by the loader's data_in/data_en inputs.
- No buffering: the consumer must take each byte in the cycle data_en is high.

Parameters:
CLKS_PER_BIT, 104, clk cycles per bit (12 MHz / 115200); legal range 8..65535
CNT_W, $clog2(CLKS_PER_BIT), derived width of the bit-period counter; not to be overridden

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
rx  in  1  raw serial line, idle high, asynchronous to clk
data  out  pkg_ram::RAM_BYTE  last received byte, held until the next good byte
data_en  out  1  one-cycle strobe, data valid
frame_err  out  1  one-cycle strobe, stop bit sampled low
busy  out  1  high while a frame is being received (any state except IDLE)

Behaviour:
- Reset: rst_n is asynchronous and active-low. While low, all of the following hold: state=IDLE, counters=0, sync flops=1, data=0, data_en=0, frame_err=0, busy=0. Reset mid-frame discards the partial byte.
- Sync: rx passes through two flops (reset value 1). The FSM uses only the second flop output, rx_s. This adds 2 cycles of latency.
- States and transitions:
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: at cnt==CLKS_PER_BIT/2-1 (integer division), check rx_s. If rx_s==0, go to DATA with cnt=0, bit_idx=0. If rx_s==1 (glitch), return to IDLE and raise no strobe. Otherwise cnt++.
  - DATA: at cnt==CLKS_PER_BIT-1, shift[bit_idx]<=rx_s and cnt=0. If bit_idx==7, go to STOP; else bit_idx++. Otherwise cnt++.
  - STOP: at cnt==CLKS_PER_BIT-1, check rx_s. If rx_s==1, data<=shift, pulse data_en, go to IDLE. If rx_s==0, pulse frame_err, leave data unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. This prevents a break or stuck-low line from producing false starts.
- Sampling and latency:
  - Every sample lands mid-bit.
  - data_en rises in the cycle after the stop-bit sample: about 9.5 bit times plus 3 clk after the rx falling edge.
  - data_en and frame_err are each exactly one cycle wide and never assert together.
- Back-to-back frames: STOP returns to IDLE half a bit early, so a start bit that immediately follows the stop bit is detected with no gap required.
- Counter: cnt is CNT_W bits and never exceeds CLKS_PER_BIT-1, so there is no wrap. bit_idx is 3 bits.
- busy is 1 in START, DATA, STOP and WAIT_IDLE. It drops in the same cycle data_en pulses.

Decomposition:
- pkg_uart holds:
  - the state enum typedef (IDLE, START, DATA, STOP, WAIT_IDLE);
  - the default CLKS_PER_BIT constant;
  - UART_DATA_BITS=8.
- Byte width comes from pkg_ram::RAM_BYTE.
- One natural sub-module: sync_2ff, a generic 2-flop synchronizer with a reset value parameter (1 here).

Test Plan (CLKS_PER_BIT=16 unless noted):
1. Send 0x34 ('4') with clean 8N1 timing -> exactly one data_en pulse with data=0x34, about 155 clk after the falling edge; frame_err stays 0.
2. Send 0x3E ('>') immediately followed by 0x61 ('a'), zero idle between stop and start -> two data_en pulses with 0x3E then 0x61, 160 clk apart.
3. Drive rx low for 5 clk, then high -> no data_en, no frame_err; busy pulses high then returns to 0 with state IDLE.
4. Send 0xC3 with the stop bit held low, line low 40 more clk, then send 0x55 -> frame_err pulses once, data stays at the previous value, no false byte during the low period; then data_en with 0x55.
5. Pull rst_n low mid-DATA (after bit 3) -> data, data_en, frame_err and busy go to 0 immediately without a clock edge. Release with rx idle, send 0xA5 -> data=0xA5.
6. CLKS_PER_BIT=13 (odd), send 0xFF then 0x00 -> both received correctly, and sample points stay within ±1 clk of each bit centre.
